// File: rtl/mlp_result_scorer.sv
// mlp_result_scorer
//   Scores MLP predictions against expected targets one sample at a time.
//   Both values are thresholded into class bits (signed, strictly greater
//   than threshold); matches are counted per epoch of SAMPLES accepts.
//   Per-epoch results are latched and a sticky converged flag is raised
//   after STREAK consecutive perfect epochs.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           pulse: (re)start scoring from epoch 0
//   threshold       signed decision threshold
//   sample_valid    prediction/expected pair present
//   sample_ready    pair accepted this cycle (high only while scoring)
//   prediction      signed MLP output
//   expected        signed target value
//   epoch_done      one-cycle pulse when epoch results become valid
//   epoch_correct   correct count of the last completed epoch
//   epoch_count     completed epochs, saturating
//   converged       sticky convergence flag
//   err_sum         summed |prediction-expected| of the last epoch
//
// Build option: define MLP_SCORER_ERR_ACC_EN to build the error accumulator;
// otherwise err_sum is tied to 0.

module mlp_result_scorer #(
  parameter int DATA_W  = 32,
  parameter int SAMPLES = 4,
  parameter int STREAK  = 3,
  parameter int EPOCH_W = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic signed [DATA_W-1:0]            threshold,
  input  logic                                sample_valid,
  output logic                                sample_ready,
  input  logic signed [DATA_W-1:0]            prediction,
  input  logic signed [DATA_W-1:0]            expected,
  output logic                                epoch_done,
  output logic [$clog2(SAMPLES+1)-1:0]        epoch_correct,
  output logic [EPOCH_W-1:0]                  epoch_count,
  output logic                                converged,
  output logic [DATA_W+$clog2(SAMPLES):0]     err_sum
);

  localparam int CNT_W = $clog2(SAMPLES + 1);
  localparam int STR_W = $clog2(STREAK + 1);
  localparam int ERR_W = DATA_W + $clog2(SAMPLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCORE, S_CLOSE} state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_done;
  logic [CNT_W-1:0]   r_correct;
  logic [EPOCH_W-1:0] r_count;
  logic               r_conv;
  logic [STR_W-1:0]   r_streak;
  logic [CNT_W-1:0]   r_sample_cnt;
  logic [CNT_W-1:0]   r_run_correct;

  logic               w_accept;
  logic               w_match;
  logic               w_last;
  logic [CNT_W-1:0]   w_correct_next;
  logic               w_perfect;

  assign w_accept       = (r_state == S_SCORE) && sample_valid;
  assign w_match        = (prediction > threshold) == (expected > threshold);
  assign w_last         = w_accept && (r_sample_cnt == CNT_W'(SAMPLES - 1));
  assign w_correct_next = r_run_correct + CNT_W'(w_match);
  assign w_perfect      = (w_correct_next == CNT_W'(SAMPLES));

  // Epoch results are captured on the edge that accepts the final sample so
  // that they (and the epoch_done pulse) are visible during the CLOSE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b0;
      r_done        <= 1'b0;
      r_correct     <= '0;
      r_count       <= '0;
      r_conv        <= 1'b0;
      r_streak      <= '0;
      r_sample_cnt  <= '0;
      r_run_correct <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_state       <= S_SCORE;
        r_ready       <= 1'b1;
        r_count       <= '0;
        r_conv        <= 1'b0;
        r_streak      <= '0;
        r_sample_cnt  <= '0;
        r_run_correct <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ready <= 1'b0;
          end
          S_SCORE: begin
            if (w_last) begin
              r_state       <= S_CLOSE;
              r_ready       <= 1'b0;
              r_done        <= 1'b1;
              r_correct     <= w_correct_next;
              r_sample_cnt  <= '0;
              r_run_correct <= '0;
              if (r_count != '1) r_count <= r_count + 1'b1;
              if (w_perfect) begin
                if (r_streak != STR_W'(STREAK)) r_streak <= r_streak + 1'b1;
                if (r_streak >= STR_W'(STREAK - 1)) r_conv <= 1'b1;
              end else begin
                r_streak <= '0;
              end
            end else if (w_accept) begin
              r_sample_cnt  <= r_sample_cnt + 1'b1;
              r_run_correct <= w_correct_next;
            end
          end
          S_CLOSE: begin
            r_state <= S_SCORE;
            r_ready <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sample_ready  = r_ready;
  assign epoch_done    = r_done;
  assign epoch_correct = r_correct;
  assign epoch_count   = r_count;
  assign converged     = r_conv;

`ifdef MLP_SCORER_ERR_ACC_EN
  logic signed [DATA_W:0] w_diff;
  logic [DATA_W:0]        w_abs;
  logic [ERR_W:0]         w_sum;
  logic [ERR_W-1:0]       w_acc_next;
  logic [ERR_W-1:0]       r_err_acc;
  logic [ERR_W-1:0]       r_err_sum;

  // Difference is formed one bit wider so |a-b| never overflows.
  always_comb begin
    w_diff     = {prediction[DATA_W-1], prediction} - {expected[DATA_W-1], expected};
    w_abs      = w_diff[DATA_W] ? (~$unsigned(w_diff) + 1'b1) : $unsigned(w_diff);
    w_sum      = {1'b0, r_err_acc} + (ERR_W+1)'(w_abs);
    w_acc_next = w_sum[ERR_W] ? '1 : w_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_acc <= '0;
      r_err_sum <= '0;
    end else if (start) begin
      r_err_acc <= '0;
    end else if (w_last) begin
      r_err_sum <= w_acc_next;
      r_err_acc <= '0;
    end else if (w_accept) begin
      r_err_acc <= w_acc_next;
    end
  end

  assign err_sum = r_err_sum;
`else
  assign err_sum = '0;
`endif

endmodule

// File: tb/tb_mlp_result_scorer.sv
module tb_mlp_result_scorer;

  localparam int DATA_W  = 32;
  localparam int SAMPLES = 4;
  localparam int STREAK  = 2;
  localparam int EPOCH_W = 16;

  localparam logic signed [31:0] ONE  = 32'sh0001_0000;
  localparam logic signed [31:0] HALF = 32'sh0000_8000;
  localparam logic signed [31:0] ZERO = 32'sh0000_0000;
  localparam logic signed [31:0] MONE = -32'sh0001_0000;

  logic                             clk;
  logic                             rst;
  logic                             start;
  logic signed [DATA_W-1:0]         threshold;
  logic                             sample_valid;
  logic                             sample_ready;
  logic signed [DATA_W-1:0]         prediction;
  logic signed [DATA_W-1:0]         expected;
  logic                             epoch_done;
  logic [$clog2(SAMPLES+1)-1:0]     epoch_correct;
  logic [EPOCH_W-1:0]               epoch_count;
  logic                             converged;
  logic [DATA_W+$clog2(SAMPLES):0]  err_sum;

  int vectors     = 0;
  int miscompares = 0;

  mlp_result_scorer #(
    .DATA_W (DATA_W),
    .SAMPLES(SAMPLES),
    .STREAK (STREAK),
    .EPOCH_W(EPOCH_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .threshold    (threshold),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .prediction   (prediction),
    .expected     (expected),
    .epoch_done   (epoch_done),
    .epoch_correct(epoch_correct),
    .epoch_count  (epoch_count),
    .converged    (converged),
    .err_sum      (err_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] errx(input logic [63:0] v);
`ifdef MLP_SCORER_ERR_ACC_EN
    return v;
`else
    return 64'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present a pair and hold it until accepted; returns at the negedge after
  // the accepting edge.
  task automatic send(input logic signed [31:0] p, input logic signed [31:0] e);
    int waited;
    waited       = 0;
    prediction   = p;
    expected     = e;
    sample_valid = 1'b1;
    while (!sample_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_accept", {63'd0, sample_ready}, 64'd1);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_close(input string tag, input int corr, input int cnt,
                             input logic conv, input logic [63:0] err);
    check({tag, "_done"},    {63'd0, epoch_done},   64'd1);
    check({tag, "_ready"},   {63'd0, sample_ready}, 64'd0);
    check({tag, "_correct"}, 64'(epoch_correct),    64'(corr));
    check({tag, "_count"},   64'(epoch_count),      64'(cnt));
    check({tag, "_conv"},    {63'd0, converged},    {63'd0, conv});
    check({tag, "_err"},     64'(err_sum),          errx(err));
  endtask

  initial begin
    int cycles;
    int accepts;
    int dones;
    int gaps;

    rst          = 1'b1;
    start        = 1'b0;
    threshold    = HALF;
    sample_valid = 1'b0;
    prediction   = ZERO;
    expected     = ZERO;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready",   {63'd0, sample_ready}, 64'd0);
    check("rst_done",    {63'd0, epoch_done},   64'd0);
    check("rst_correct", 64'(epoch_correct),    64'd0);
    check("rst_count",   64'(epoch_count),      64'd0);
    check("rst_conv",    {63'd0, converged},    64'd0);
    check("rst_err",     64'(err_sum),          64'd0);

    pulse_start();
    check("start_ready", {63'd0, sample_ready}, 64'd1);

    // Test 1: two perfect epochs -> converged on second CLOSE
    send(ZERO, ZERO); send(ZERO, ZERO); send(ZERO, ZERO); send(ONE, ONE);
    check_close("epA", 4, 1, 1'b0, 64'd0);
    @(negedge clk);
    check("epA_pulse_end", {63'd0, epoch_done}, 64'd0);
    send(ZERO, ZERO); send(ZERO, ZERO); send(ZERO, ZERO); send(ONE, ONE);
    check_close("epB", 4, 2, 1'b1, 64'd0);

    // Restart clears converged and epoch count
    @(negedge clk);
    pulse_start();
    check("restart_count", 64'(epoch_count),   64'd0);
    check("restart_conv",  {63'd0, converged}, 64'd0);

    // Test 2: equality classifies as 0 -> 3 correct
    send(HALF, ONE); send(ZERO, ZERO); send(ZERO, ZERO); send(ONE, ONE);
    check_close("epC", 3, 1, 1'b0, 64'h8000);
    @(negedge clk);
    // Negative prediction stays below threshold under signed compare
    send(MONE, ZERO); send(ZERO, ZERO); send(ONE, ONE); send(ZERO, ZERO);
    check_close("epD", 4, 2, 1'b0, 64'h10000);
    @(negedge clk);
    send(ZERO, ZERO); send(ZERO, ZERO); send(ZERO, ZERO); send(ONE, ONE);
    check_close("epE", 4, 3, 1'b1, 64'd0);

    // Test 3: continuous valid across the epoch boundary
    @(negedge clk);
    check("epE_pulse_end", {63'd0, epoch_done}, 64'd0);
    prediction   = ZERO;
    expected     = ZERO;
    sample_valid = 1'b1;
    cycles  = 0;
    accepts = 0;
    dones   = 0;
    gaps    = 0;
    while (accepts < 8 && cycles < 40) begin
      if (epoch_done) dones++;
      if (sample_ready) accepts++;
      else gaps++;
      cycles++;
      @(negedge clk);
    end
    if (epoch_done) dones++;
    sample_valid = 1'b0;
    check("stream_accepts", 64'(accepts), 64'd8);
    check("stream_cycles",  64'(cycles),  64'd9);
    check("stream_gaps",    64'(gaps),    64'd1);
    check("stream_dones",   64'(dones),   64'd2);
    check_close("epStream", 4, 5, 1'b1, 64'd0);

    // Test 4: start after 2 of 4 samples discards the partial epoch
    @(negedge clk);
    send(ZERO, ZERO); send(ZERO, ZERO);
    pulse_start();
    check("abort_done",  {63'd0, epoch_done},   64'd0);
    check("abort_count", 64'(epoch_count),      64'd0);
    check("abort_conv",  {63'd0, converged},    64'd0);
    check("abort_ready", {63'd0, sample_ready}, 64'd1);
    // Test 6 vectors: two wrong, two right, |err| = 2*ONE
    send(ONE, ZERO); send(ZERO, ONE); send(HALF, HALF); send(ZERO, ZERO);
    check_close("epAbort", 2, 1, 1'b0, 64'h20000);

    // Test 5: reset mid-epoch while converged
    @(negedge clk);
    send(ZERO, ZERO); send(ZERO, ZERO); send(ZERO, ZERO); send(ONE, ONE);
    check_close("epF", 4, 2, 1'b0, 64'd0);
    @(negedge clk);
    send(ZERO, ZERO); send(ZERO, ZERO); send(ZERO, ZERO); send(ONE, ONE);
    check_close("epG", 4, 3, 1'b1, 64'd0);
    @(negedge clk);
    send(ONE, ONE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready",   {63'd0, sample_ready}, 64'd0);
    check("mid_rst_done",    {63'd0, epoch_done},   64'd0);
    check("mid_rst_correct", 64'(epoch_correct),    64'd0);
    check("mid_rst_count",   64'(epoch_count),      64'd0);
    check("mid_rst_conv",    {63'd0, converged},    64'd0);
    check("mid_rst_err",     64'(err_sum),          64'd0);
    sample_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", {63'd0, sample_ready}, 64'd0);
    check("idle_count", 64'(epoch_count),      64'd0);
    sample_valid = 1'b0;
    pulse_start();
    check("post_rst_start_ready", {63'd0, sample_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
